// File: rtl/load_store_dep_checker.sv
// Load/store dependence checker.
//
// When a load fires, this block searches the store queue for the youngest
// older store to the same address. The store queue is a ring buffer, so ages
// are measured relative to stq_head. The response is registered and appears
// one cycle after the load fires:
//   - no dependent store      : all outputs 0
//   - youngest has its data   : kill_mem_req=1, forward=1, stq_forward_index=Y
//   - youngest lacks its data : kill_mem_req=1, sleep=1, sleep_rob_tag=tag(Y)
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   ldq_address            LDQ_SIZE packed load addresses (entry k at [k*XLEN +: XLEN])
//   ldq_store_mask         LDQ_SIZE packed masks; bit i = store i is older than the load
//   stq_valid              store entry valid
//   stq_address            STQ_SIZE packed store addresses
//   stq_address_valid      store address known
//   stq_data_valid         store data present
//   stq_rob_tag            STQ_SIZE packed ROB tags
//   stq_head               index of the oldest store
//   load_fired             a load issues this cycle
//   load_fired_ldq_index   LDQ index of that load
//   kill_mem_req           cancel the load's memory request
//   sleep, sleep_rob_tag   load must wait on the store with this ROB tag
//   forward                forward store data to the load
//   stq_forward_index      store entry to forward from
module load_store_dep_checker #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_TAG_WIDTH = 32,
    parameter int unsigned LDQ_SIZE      = 16,
    parameter int unsigned STQ_SIZE      = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [LDQ_SIZE*XLEN-1:0]         ldq_address,
    input  logic [LDQ_SIZE*STQ_SIZE-1:0]     ldq_store_mask,
    input  logic [STQ_SIZE-1:0]              stq_valid,
    input  logic [STQ_SIZE*XLEN-1:0]         stq_address,
    input  logic [STQ_SIZE-1:0]              stq_address_valid,
    input  logic [STQ_SIZE-1:0]              stq_data_valid,
    input  logic [STQ_SIZE*ROB_TAG_WIDTH-1:0] stq_rob_tag,
    input  logic [$clog2(STQ_SIZE)-1:0]      stq_head,
    input  logic                             load_fired,
    input  logic [$clog2(LDQ_SIZE)-1:0]      load_fired_ldq_index,
    output logic                             kill_mem_req,
    output logic                             sleep,
    output logic [ROB_TAG_WIDTH-1:0]         sleep_rob_tag,
    output logic                             forward,
    output logic [$clog2(STQ_SIZE)-1:0]      stq_forward_index
);

    localparam int unsigned StqIdxW = $clog2(STQ_SIZE);

    logic [XLEN-1:0]          ld_addr;
    logic [STQ_SIZE-1:0]      ld_mask;
    logic [STQ_SIZE-1:0]      dep;
    logic                     found;
    logic [StqIdxW-1:0]       y_idx;
    logic [StqIdxW-1:0]       y_age;
    logic [StqIdxW-1:0]       age;

    logic                     kill_d, kill_q;
    logic                     sleep_d, sleep_q;
    logic [ROB_TAG_WIDTH-1:0] tag_d, tag_q;
    logic                     fwd_d, fwd_q;
    logic [StqIdxW-1:0]       idx_d, idx_q;

    // Dependence vector. Gating on stq_valid first keeps X on invalid entries
    // from reaching the compare result.
    always_comb begin
        ld_addr = ldq_address[load_fired_ldq_index*XLEN +: XLEN];
        ld_mask = ldq_store_mask[load_fired_ldq_index*STQ_SIZE +: STQ_SIZE];
        dep     = '0;
        for (int i = 0; i < STQ_SIZE; i++) begin
            dep[i] = stq_valid[i] && stq_address_valid[i] && ld_mask[i] &&
                     (stq_address[i*XLEN +: XLEN] == ld_addr);
        end
    end

    // Youngest dependent store: maximum (i - head) mod STQ_SIZE. The
    // subtraction wraps naturally at StqIdxW bits; ages are unique, so no ties.
    always_comb begin
        found = 1'b0;
        y_idx = '0;
        y_age = '0;
        age   = '0;
        for (int i = 0; i < STQ_SIZE; i++) begin
            age = StqIdxW'(i) - stq_head;
            if (dep[i] && (!found || age > y_age)) begin
                found = 1'b1;
                y_idx = StqIdxW'(i);
                y_age = age;
            end
        end
    end

    // Only Y's data readiness matters; older dependent stores are ignored.
    always_comb begin
        kill_d  = 1'b0;
        sleep_d = 1'b0;
        tag_d   = '0;
        fwd_d   = 1'b0;
        idx_d   = '0;
        if (load_fired && found) begin
            kill_d = 1'b1;
            if (stq_data_valid[y_idx]) begin
                fwd_d = 1'b1;
                idx_d = y_idx;
            end else begin
                sleep_d = 1'b1;
                tag_d   = stq_rob_tag[y_idx*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kill_q  <= 1'b0;
            sleep_q <= 1'b0;
            tag_q   <= '0;
            fwd_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            kill_q  <= kill_d;
            sleep_q <= sleep_d;
            tag_q   <= tag_d;
            fwd_q   <= fwd_d;
            idx_q   <= idx_d;
        end
    end

    assign kill_mem_req      = kill_q;
    assign sleep             = sleep_q;
    assign sleep_rob_tag     = tag_q;
    assign forward           = fwd_q;
    assign stq_forward_index = idx_q;

endmodule

// File: tb/tb_load_store_dep_checker.sv
// Scoreboard bench for load_store_dep_checker: the stimulus process drives a
// vector on the falling edge and queues its expected registered response; the
// monitor pops and compares just after each rising edge.
module tb_load_store_dep_checker;

    localparam int XLEN = 32;
    localparam int RT   = 32;
    localparam int LDQ  = 16;
    localparam int STQ  = 16;

    localparam logic [31:0] AddrA = 32'h1000_0040;
    localparam logic [31:0] AddrB = 32'h2000_0080;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [LDQ*XLEN-1:0] ldq_address;
    logic [LDQ*STQ-1:0]  ldq_store_mask;
    logic [STQ-1:0]      stq_valid;
    logic [STQ*XLEN-1:0] stq_address;
    logic [STQ-1:0]      stq_address_valid;
    logic [STQ-1:0]      stq_data_valid;
    logic [STQ*RT-1:0]   stq_rob_tag;
    logic [3:0]          stq_head;
    logic                load_fired;
    logic [3:0]          load_fired_ldq_index;
    logic                kill_mem_req;
    logic                sleep;
    logic [RT-1:0]       sleep_rob_tag;
    logic                forward;
    logic [3:0]          stq_forward_index;

    always #5 clk = ~clk;

    load_store_dep_checker #(
        .XLEN          (XLEN),
        .ROB_TAG_WIDTH (RT),
        .LDQ_SIZE      (LDQ),
        .STQ_SIZE      (STQ)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .ldq_address          (ldq_address),
        .ldq_store_mask       (ldq_store_mask),
        .stq_valid            (stq_valid),
        .stq_address          (stq_address),
        .stq_address_valid    (stq_address_valid),
        .stq_data_valid       (stq_data_valid),
        .stq_rob_tag          (stq_rob_tag),
        .stq_head             (stq_head),
        .load_fired           (load_fired),
        .load_fired_ldq_index (load_fired_ldq_index),
        .kill_mem_req         (kill_mem_req),
        .sleep                (sleep),
        .sleep_rob_tag        (sleep_rob_tag),
        .forward              (forward),
        .stq_forward_index    (stq_forward_index)
    );

    typedef struct packed {
        logic          kill;
        logic          slp;
        logic [RT-1:0] tag;
        logic          fwd;
        logic [3:0]    idx;
    } resp_t;

    resp_t exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic resp_t rsp(logic k, logic s, logic [RT-1:0] t, logic f, logic [3:0] i);
        resp_t r;
        r.kill = k;
        r.slp  = s;
        r.tag  = t;
        r.fwd  = f;
        r.idx  = i;
        return r;
    endfunction

    // Monitor: the DUT presents a registered response every cycle.
    always @(posedge clk) begin
        resp_t e;
        resp_t got;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {kill_mem_req, sleep, sleep_rob_tag, forward, stq_forward_index};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got kill=%b sleep=%b tag=%0d fwd=%b idx=%0d, want kill=%b sleep=%b tag=%0d fwd=%b idx=%0d",
                         nm, got.kill, got.slp, got.tag, got.fwd, got.idx,
                         e.kill, e.slp, e.tag, e.fwd, e.idx);
            end
        end
    end

    // Unselected LDQ entries and invalid STQ fields are X so leakage shows up.
    task automatic clear_inputs();
        ldq_address          = 'x;
        ldq_store_mask       = 'x;
        stq_valid            = '0;
        stq_address          = 'x;
        stq_address_valid    = 'x;
        stq_data_valid       = 'x;
        stq_rob_tag          = 'x;
        stq_head             = 4'd0;
        load_fired           = 1'b0;
        load_fired_ldq_index = 4'd0;
    endtask

    task automatic set_ld(int l, logic [31:0] a, logic [15:0] m);
        load_fired                       = 1'b1;
        load_fired_ldq_index             = 4'(l);
        ldq_address[l*XLEN +: XLEN]      = a;
        ldq_store_mask[l*STQ +: STQ]     = m;
    endtask

    task automatic set_st(int i, logic [31:0] a, logic av, logic dv, logic [31:0] t);
        stq_valid[i]                = 1'b1;
        stq_address[i*XLEN +: XLEN] = a;
        stq_address_valid[i]        = av;
        stq_data_valid[i]           = dv;
        stq_rob_tag[i*RT +: RT]     = t;
    endtask

    // head=4, valid 0x0FF0, addr_valid 0x07F0, data_valid 0x0190;
    // 5/7/10 match (tags 13/20/34); 11 matches but its address is unknown.
    task automatic cfg_sleep();
        clear_inputs();
        stq_head = 4'd4;
        set_ld(3, AddrA, 16'hFFFF);
        set_st(4,  AddrB, 1'b1, 1'b1, 32'd1);
        set_st(5,  AddrA, 1'b1, 1'b0, 32'd13);
        set_st(6,  AddrB, 1'b1, 1'b0, 32'd2);
        set_st(7,  AddrA, 1'b1, 1'b1, 32'd20);
        set_st(8,  AddrB, 1'b1, 1'b1, 32'd3);
        set_st(9,  AddrB, 1'b1, 1'b0, 32'd4);
        set_st(10, AddrA, 1'b1, 1'b0, 32'd34);
        set_st(11, AddrA, 1'b0, 1'b0, 32'd99);
        stq_data_valid[4] = 1'b1;
        stq_data_valid[5] = 1'b0;
    endtask

    // Queue the expectation for the coming rising edge, then move to the next falling edge.
    task automatic step(string nm, resp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        resp_t zero;
        resp_t slp34;
        zero  = rsp(1'b0, 1'b0, 32'd0, 1'b0, 4'd0);
        slp34 = rsp(1'b1, 1'b1, 32'd34, 1'b0, 4'd0);

        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        step("reset_idle", zero);
        reset_n = 1'b1;

        clear_inputs();
        set_ld(12, 32'hDEAD_BEEF, 16'hFFFF);
        step("empty_queue", zero);

        cfg_sleep();
        step("sleep_youngest", slp34);

        cfg_sleep();
        set_st(12, AddrA, 1'b1, 1'b1, 32'd50);
        step("forward_youngest", rsp(1'b1, 1'b0, 32'd0, 1'b1, 4'd12));

        clear_inputs();
        stq_head = 4'd14;
        set_ld(3, AddrA, 16'hFFFF);
        set_st(15, AddrA, 1'b1, 1'b0, 32'd7);
        set_st(1,  AddrA, 1'b1, 1'b1, 32'd8);
        step("wrap_forward", rsp(1'b1, 1'b0, 32'd0, 1'b1, 4'd1));

        clear_inputs();
        stq_head = 4'd14;
        set_ld(3, AddrA, 16'hFFFF);
        set_st(15, AddrA, 1'b1, 1'b1, 32'd7);
        set_st(1,  AddrA, 1'b1, 1'b0, 32'd8);
        step("wrap_sleep", rsp(1'b1, 1'b1, 32'd8, 1'b0, 4'd0));

        clear_inputs();
        set_ld(7, AddrB, 16'hFFFF);
        set_st(3, AddrB, 1'b1, 1'b1, 32'd3);
        set_st(9, AddrB, 1'b1, 1'b0, 32'd9);
        step("head0_sleep", rsp(1'b1, 1'b1, 32'd9, 1'b0, 4'd0));

        clear_inputs();
        set_ld(7, AddrB, 16'hFFFF);
        set_st(3, AddrB, 1'b1, 1'b0, 32'd3);
        set_st(9, AddrB, 1'b1, 1'b1, 32'd9);
        step("head0_forward", rsp(1'b1, 1'b0, 32'd0, 1'b1, 4'd9));

        clear_inputs();
        set_ld(0, AddrA, 16'hFFDF);
        set_st(5, AddrA, 1'b1, 1'b1, 32'd5);
        step("mask_clear", zero);

        clear_inputs();
        set_ld(0, AddrA, 16'hFFFF);
        set_st(5, AddrA, 1'b0, 1'b1, 32'd5);
        step("addr_unknown", zero);

        clear_inputs();
        set_ld(0, AddrA, 16'hFFFF);
        set_st(5, AddrA ^ 32'h1, 1'b1, 1'b1, 32'd5);
        step("addr_mismatch", zero);

        cfg_sleep();
        load_fired = 1'b0;
        step("not_fired", zero);

        cfg_sleep();
        reset_n = 1'b0;
        step("reset_overrides", zero);
        reset_n = 1'b1;
        step("after_release", slp34);

        reset_n = 1'b0;
        step("reset_drop", zero);
        reset_n = 1'b1;
        load_fired = 1'b0;
        step("dropped_load", zero);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
